// File: rtl/control_pkg.sv
// Shared types and constants for the interrupt sequencer and its arbiter.
package control_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned STEP_W = 3;

  localparam logic [ADDR_W-1:0] NMI_VECTOR_DEF   = 16'hFFFA;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 16'hFFFC;
  localparam logic [ADDR_W-1:0] IRQ_VECTOR_DEF   = 16'hFFFE;

  typedef enum logic [1:0] {
    SRC_RESET,
    SRC_NMI,
    SRC_IRQ,
    SRC_BRK
  } int_src_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0_FORCE,
    ST_T1_DUMMY,
    ST_T2_PCH,
    ST_T3_PCL,
    ST_T4_P,
    ST_T5_VLO,
    ST_T6_VHI
  } int_state_t;

  // Step number T0..T6 for an active state; idle reads as 0.
  function automatic logic [STEP_W-1:0] state_step(input int_state_t s);
    if (s == ST_IDLE) return '0;
    return STEP_W'(s) - STEP_W'(1);
  endfunction

endpackage

// File: rtl/interrupt_arbiter.sv
// Fixed-priority pick among pending interrupt sources at an instruction boundary.
module interrupt_arbiter
  import control_pkg::*;
(
  input  logic     reset_req_i,
  input  logic     nmi_i,
  input  logic     irq_i,
  input  logic     brk_i,
  output int_src_t src_c_o,
  output logic     valid_c_o
);

  // Priority: reset > NMI > IRQ > BRK.
  always_comb begin
    src_c_o   = SRC_RESET;
    valid_c_o = 1'b1;
    if (reset_req_i) begin
      src_c_o = SRC_RESET;
    end else if (nmi_i) begin
      src_c_o = SRC_NMI;
    end else if (irq_i) begin
      src_c_o = SRC_IRQ;
    end else if (brk_i) begin
      src_c_o = SRC_BRK;
    end else begin
      valid_c_o = 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style 7-cycle interrupt micro-sequencer: arbitration, stack pushes,
// vector fetch, NMI hijack of IRQ/BRK, and pending-flop acknowledges.
module interrupt_sequencer
  import control_pkg::*;
#(
  parameter logic [ADDR_W-1:0] NMI_VECTOR   = NMI_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = IRQ_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              instr_boundary,
  input  logic              reset_req,
  input  logic              nmi_generated,
  input  logic              irq_generated,
  input  logic              brk_decoded,
  output logic              seq_active,
  output logic [STEP_W-1:0] seq_step,
  output logic [ADDR_W-1:0] vector_addr,
  output logic              stack_write_en,
  output logic              pushed_b_flag,
  output logic              inhibit_pc_inc,
  output logic              set_i_flag,
  output logic              irq_ack,
  output logic              nmi_ack
);

  int_state_t        state_q, state_d;
  int_src_t          src_q, src_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              b_q, b_d;
  logic              hijack_q, hijack_d;
  logic              active_q, active_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              swe_q, swe_d;
  logic              inh_q, inh_d;

  int_src_t          arb_src;
  logic              arb_valid;
  logic              hijackable;

  interrupt_arbiter u_arb (
    .reset_req_i (reset_req),
    .nmi_i       (nmi_generated),
    .irq_i       (irq_generated),
    .brk_i       (brk_decoded),
    .src_c_o     (arb_src),
    .valid_c_o   (arb_valid)
  );

  assign hijackable = (src_q == SRC_IRQ) || (src_q == SRC_BRK);

  // Next-state, latched source/vector, and same-cycle pulse generation.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    vec_d      = vec_q;
    b_d        = b_q;
    hijack_d   = hijack_q;
    irq_ack    = 1'b0;
    nmi_ack    = 1'b0;
    set_i_flag = 1'b0;

    if (ready) begin
      case (state_q)
        ST_IDLE: begin
          if (instr_boundary && arb_valid) begin
            state_d  = ST_T0_FORCE;
            src_d    = arb_src;
            b_d      = (arb_src == SRC_BRK);
            hijack_d = 1'b0;
            irq_ack  = (arb_src == SRC_IRQ);
            nmi_ack  = (arb_src == SRC_NMI);
          end
        end
        ST_T0_FORCE: state_d = ST_T1_DUMMY;
        ST_T1_DUMMY, ST_T2_PCH, ST_T3_PCL: begin
          state_d = int_state_t'(3'(state_q) + 3'd1);
          if (nmi_generated && hijackable) hijack_d = 1'b1;
        end
        ST_T4_P: begin
          state_d = ST_T5_VLO;
          // A pending NMI steals the vector of an IRQ/BRK in flight.
          if (hijack_q || (nmi_generated && hijackable)) begin
            src_d   = SRC_NMI;
            nmi_ack = 1'b1;
          end
          case (src_d)
            SRC_NMI:   vec_d = NMI_VECTOR;
            SRC_RESET: vec_d = RESET_VECTOR;
            default:   vec_d = IRQ_VECTOR;
          endcase
        end
        ST_T5_VLO: state_d = ST_T6_VHI;
        ST_T6_VHI: begin
          state_d    = ST_IDLE;
          set_i_flag = 1'b1;
          b_d        = 1'b0;
          hijack_d   = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // An aborted sequence must not clear pending flops or touch P.I.
    if (rst) begin
      irq_ack    = 1'b0;
      nmi_ack    = 1'b0;
      set_i_flag = 1'b0;
    end

    active_d = (state_d != ST_IDLE);
    step_d   = state_step(state_d);
    swe_d    = (state_d inside {ST_T2_PCH, ST_T3_PCL, ST_T4_P}) && (src_d != SRC_RESET);
    inh_d    = (state_d inside {ST_T0_FORCE, ST_T1_DUMMY}) && (src_d != SRC_BRK);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_RESET;
      vec_q    <= RESET_VECTOR;
      b_q      <= 1'b0;
      hijack_q <= 1'b0;
      active_q <= 1'b0;
      step_q   <= '0;
      swe_q    <= 1'b0;
      inh_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      vec_q    <= vec_d;
      b_q      <= b_d;
      hijack_q <= hijack_d;
      active_q <= active_d;
      step_q   <= step_d;
      swe_q    <= swe_d;
      inh_q    <= inh_d;
    end
  end

  assign seq_active     = active_q;
  assign seq_step       = step_q;
  assign vector_addr    = vec_q;
  assign stack_write_en = swe_q;
  assign pushed_b_flag  = b_q;
  assign inhibit_pc_inc = inh_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: per-cycle vector table through a scoreboard
// queue, plus randomized-stall IRQ runs checking pulse counts.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, ready, instr_boundary, reset_req;
  logic        nmi_generated, irq_generated, brk_decoded;
  logic        seq_active;
  logic [2:0]  seq_step;
  logic [15:0] vector_addr;
  logic        stack_write_en, pushed_b_flag, inhibit_pc_inc;
  logic        set_i_flag, irq_ack, nmi_ack;

  interrupt_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .instr_boundary (instr_boundary),
    .reset_req      (reset_req),
    .nmi_generated  (nmi_generated),
    .irq_generated  (irq_generated),
    .brk_decoded    (brk_decoded),
    .seq_active     (seq_active),
    .seq_step       (seq_step),
    .vector_addr    (vector_addr),
    .stack_write_en (stack_write_en),
    .pushed_b_flag  (pushed_b_flag),
    .inhibit_pc_inc (inhibit_pc_inc),
    .set_i_flag     (set_i_flag),
    .irq_ack        (irq_ack),
    .nmi_ack        (nmi_ack)
  );

  always #5 clk = ~clk;

  // in  = {rst, ready, instr_boundary, reset_req, nmi, irq, brk}
  // fl  = {stack_write_en, pushed_b_flag, inhibit_pc_inc, set_i_flag, irq_ack, nmi_ack}
  typedef struct packed {
    logic        chk;
    logic [6:0]  in;
    logic        act;
    logic [2:0]  step;
    logic [15:0] vec;
    logic [5:0]  fl;
  } vec_t;

  vec_t        tbl[$];
  logic [25:0] exp_q[$];
  int          passed = 0;
  int          total  = 0;

  function automatic void row(input logic chk, input logic [6:0] in, input logic act,
                              input logic [2:0] st, input logic [15:0] vec, input logic [5:0] fl);
    vec_t v;
    v.chk = chk; v.in = in; v.act = act; v.step = st; v.vec = vec; v.fl = fl;
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic [25:0] got, exp;
    {rst, ready, instr_boundary, reset_req, nmi_generated, irq_generated, brk_decoded} = v.in;
    if (v.chk) exp_q.push_back({v.act, v.step, v.vec, v.fl});
    @(negedge clk);
    if (v.chk) begin
      got = {seq_active, seq_step, vector_addr, stack_write_en, pushed_b_flag,
             inhibit_pc_inc, set_i_flag, irq_ack, nmi_ack};
      exp = exp_q.pop_front();
      total++;
      if (got === exp) passed++;
      else $display("FAIL row%0d: got act=%b step=%0d vec=%h fl=%b, expected act=%b step=%0d vec=%h fl=%b",
                    idx, got[25], got[24:22], got[21:6], got[5:0],
                    exp[25], exp[24:22], exp[21:6], exp[5:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // IRQ taken with ready toggled randomly; every pulse must appear exactly once.
  task automatic irq_stall_run(input int run);
    int  n_seti = 0, n_iack = 0, n_nack = 0, n_adv = 0;
    bit  done = 1'b0;
    rst = 0; ready = 1; instr_boundary = 1; reset_req = 0;
    nmi_generated = 0; irq_generated = 1; brk_decoded = 0;
    @(negedge clk);
    n_iack += int'(irq_ack);
    @(posedge clk); #1;
    instr_boundary = 0; irq_generated = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!seq_active) done = 1'b1;
      else begin
        n_seti += int'(set_i_flag);
        n_iack += int'(irq_ack);
        n_nack += int'(nmi_ack);
        if (ready) n_adv++;
      end
      @(posedge clk); #1;
    end
    check($sformatf("stall%0d_done", run), int'(done), 1);
    check($sformatf("stall%0d_adv_cycles", run), n_adv, 7);
    check($sformatf("stall%0d_set_i", run), n_seti, 1);
    check($sformatf("stall%0d_irq_ack", run), n_iack, 1);
    check($sformatf("stall%0d_nmi_ack", run), n_nack, 0);
    check($sformatf("stall%0d_vector", run), int'(vector_addr), 32'hFFFE);
  endtask

  initial begin
    {rst, ready, instr_boundary, reset_req, nmi_generated, irq_generated, brk_decoded} = 7'b1000000;

    // Power-on reset sequence
    row(0, 7'b1100000, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b1100000, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0111000, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0101000, 1, 0, 16'hFFFC, 6'b001000);
    row(1, 7'b0100000, 1, 1, 16'hFFFC, 6'b001000);
    row(1, 7'b0100000, 1, 2, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 1, 3, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 1, 4, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 1, 5, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 1, 6, 16'hFFFC, 6'b000100);
    row(1, 7'b0100000, 0, 0, 16'hFFFC, 6'b000000);
    // IRQ; boundary and reset_req during T2 are ignored
    row(1, 7'b0110010, 0, 0, 16'hFFFC, 6'b000010);
    row(1, 7'b0100000, 1, 0, 16'hFFFC, 6'b001000);
    row(1, 7'b0100000, 1, 1, 16'hFFFC, 6'b001000);
    row(1, 7'b0111000, 1, 2, 16'hFFFC, 6'b100000);
    row(1, 7'b0100000, 1, 3, 16'hFFFC, 6'b100000);
    row(1, 7'b0100000, 1, 4, 16'hFFFC, 6'b100000);
    row(1, 7'b0100000, 1, 5, 16'hFFFE, 6'b000000);
    row(1, 7'b0100000, 1, 6, 16'hFFFE, 6'b000100);
    row(1, 7'b0100000, 0, 0, 16'hFFFE, 6'b000000);
    // NMI + IRQ together: NMI first, IRQ at the next boundary
    row(1, 7'b0110110, 0, 0, 16'hFFFE, 6'b000001);
    row(1, 7'b0100010, 1, 0, 16'hFFFE, 6'b001000);
    row(1, 7'b0100010, 1, 1, 16'hFFFE, 6'b001000);
    row(1, 7'b0100010, 1, 2, 16'hFFFE, 6'b100000);
    row(1, 7'b0100010, 1, 3, 16'hFFFE, 6'b100000);
    row(1, 7'b0100010, 1, 4, 16'hFFFE, 6'b100000);
    row(1, 7'b0100010, 1, 5, 16'hFFFA, 6'b000000);
    row(1, 7'b0100010, 1, 6, 16'hFFFA, 6'b000100);
    row(1, 7'b0110010, 0, 0, 16'hFFFA, 6'b000010);
    row(1, 7'b0100000, 1, 0, 16'hFFFA, 6'b001000);
    row(1, 7'b0100000, 1, 1, 16'hFFFA, 6'b001000);
    row(1, 7'b0100000, 1, 2, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 3, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 4, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 5, 16'hFFFE, 6'b000000);
    row(1, 7'b0100000, 1, 6, 16'hFFFE, 6'b000100);
    // BRK hijacked by NMI arriving in T3
    row(1, 7'b0110001, 0, 0, 16'hFFFE, 6'b000000);
    row(1, 7'b0100000, 1, 0, 16'hFFFE, 6'b010000);
    row(1, 7'b0100000, 1, 1, 16'hFFFE, 6'b010000);
    row(1, 7'b0100000, 1, 2, 16'hFFFE, 6'b110000);
    row(1, 7'b0100100, 1, 3, 16'hFFFE, 6'b110000);
    row(1, 7'b0100100, 1, 4, 16'hFFFE, 6'b110001);
    row(1, 7'b0100000, 1, 5, 16'hFFFA, 6'b010000);
    row(1, 7'b0100000, 1, 6, 16'hFFFA, 6'b010100);
    row(1, 7'b0100000, 0, 0, 16'hFFFA, 6'b000000);
    // IRQ with three ready=0 cycles in T2
    row(1, 7'b0110010, 0, 0, 16'hFFFA, 6'b000010);
    row(1, 7'b0100000, 1, 0, 16'hFFFA, 6'b001000);
    row(1, 7'b0100000, 1, 1, 16'hFFFA, 6'b001000);
    row(1, 7'b0000000, 1, 2, 16'hFFFA, 6'b100000);
    row(1, 7'b0010000, 1, 2, 16'hFFFA, 6'b100000);
    row(1, 7'b0000000, 1, 2, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 2, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 3, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 4, 16'hFFFA, 6'b100000);
    row(1, 7'b0100000, 1, 5, 16'hFFFE, 6'b000000);
    row(1, 7'b0100000, 1, 6, 16'hFFFE, 6'b000100);
    row(1, 7'b0100000, 0, 0, 16'hFFFE, 6'b000000);
    // rst in T4 with NMI pending: no ack, everything cleared
    row(1, 7'b0110010, 0, 0, 16'hFFFE, 6'b000010);
    row(1, 7'b0100000, 1, 0, 16'hFFFE, 6'b001000);
    row(1, 7'b0100000, 1, 1, 16'hFFFE, 6'b001000);
    row(1, 7'b0100000, 1, 2, 16'hFFFE, 6'b100000);
    row(1, 7'b0100000, 1, 3, 16'hFFFE, 6'b100000);
    row(1, 7'b1100100, 1, 4, 16'hFFFE, 6'b100000);
    row(1, 7'b0100000, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0110000, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0010010, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 0, 0, 16'hFFFC, 6'b000000);
    // reset_req beats NMI/IRQ; NMI never hijacks a reset sequence
    row(1, 7'b0111110, 0, 0, 16'hFFFC, 6'b000000);
    row(1, 7'b0100110, 1, 0, 16'hFFFC, 6'b001000);
    row(1, 7'b0100110, 1, 1, 16'hFFFC, 6'b001000);
    row(1, 7'b0100110, 1, 2, 16'hFFFC, 6'b000000);
    row(1, 7'b0100110, 1, 3, 16'hFFFC, 6'b000000);
    row(1, 7'b0100110, 1, 4, 16'hFFFC, 6'b000000);
    row(1, 7'b0100110, 1, 5, 16'hFFFC, 6'b000000);
    row(1, 7'b0100000, 1, 6, 16'hFFFC, 6'b000100);
    row(1, 7'b0100000, 0, 0, 16'hFFFC, 6'b000000);

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    irq_stall_run(0);
    irq_stall_run(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
